// File: rtl/i2c_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_seq_pkg
//  Description : Shared types and constants for the I2C command sequencer.
//  Revision    : 1.0
// ============================================================================
package i2c_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_t;

    localparam int CMD_W          = 16;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_ACCEPT_TO  = 64;
    localparam int DEF_DONE_TO    = 4096;

    // Queued command record, packed as {rw, addr, wdata}
    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    function automatic cmd_t pack_cmd(input logic rw, input logic [6:0] addr,
                                      input logic [7:0] wdata);
        cmd_t c;
        c.rw    = rw;
        c.addr  = addr;
        c.wdata = wdata;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_cmd_fifo
//  Description : Synchronous command FIFO with registered occupancy count.
//  Revision    : 1.0
// ============================================================================
module i2c_cmd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int               PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0]   c_DEPTH   = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   c_CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == c_DEPTH);
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked solely by the pointers/count
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/i2c_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_cmd_sequencer
//  Description : Queues host I2C commands and drives them one at a time into
//                the I2C master, returning one response per command.
//  Revision    : 1.0
// ============================================================================
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int ACCEPT_TO  = DEF_ACCEPT_TO,
    parameter int DONE_TO    = DEF_DONE_TO
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [6:0] rsp_addr,
    output logic       rsp_rw,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [6:0] m_addr,
    output logic [7:0] m_data_in,
    output logic       m_rw,
    output logic       m_enable,
    input  logic       m_ready,
    input  logic [7:0] m_data_out,
    output logic       busy
);

    localparam int               TMR_W      = $clog2(DONE_TO) + 1;
    localparam logic [TMR_W-1:0] c_ACC_LIM  = TMR_W'(ACCEPT_TO - 1);
    localparam logic [TMR_W-1:0] c_DONE_LIM = TMR_W'(DONE_TO - 1);
    localparam logic [TMR_W-1:0] c_TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] c_TMR_MAX  = '1;

    seq_state_t       r_state, w_state_nxt;
    cmd_t             r_cmd, w_cmd_nxt;
    logic             r_m_enable, w_m_enable_nxt;
    logic [TMR_W-1:0] r_timer, w_timer_nxt;
    logic             r_rsp_valid, w_rsp_valid_nxt;
    logic [6:0]       r_rsp_addr, w_rsp_addr_nxt;
    logic             r_rsp_rw, w_rsp_rw_nxt;
    logic [7:0]       r_rsp_rdata, w_rsp_rdata_nxt;
    logic             r_rsp_err, w_rsp_err_nxt;

    cmd_t             w_fifo_din;
    cmd_t             w_fifo_dout;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_pop;
    logic             w_to_resp;

    assign w_fifo_din = pack_cmd(cmd_rw, cmd_addr, cmd_wdata);
    assign cmd_ready  = !w_fifo_full;

    i2c_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .pop   (w_pop),
        .din   (w_fifo_din),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_nxt       = r_cmd;
        w_m_enable_nxt  = r_m_enable;
        w_timer_nxt     = (r_timer == c_TMR_MAX) ? r_timer : r_timer + c_TMR_ONE;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_addr_nxt  = r_rsp_addr;
        w_rsp_rw_nxt    = r_rsp_rw;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_pop           = 1'b0;
        w_to_resp       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty && m_ready) begin
                    w_pop          = 1'b1;
                    w_cmd_nxt      = w_fifo_dout;
                    w_m_enable_nxt = 1'b1;
                    w_timer_nxt    = '0;
                    w_state_nxt    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!m_ready) begin
                    w_m_enable_nxt = 1'b0;
                    w_timer_nxt    = '0;
                    w_state_nxt    = ST_BUSY;
                end else if (r_timer == c_ACC_LIM) begin
                    w_m_enable_nxt  = 1'b0;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = 8'h00;
                    w_to_resp       = 1'b1;
                end
            end
            ST_BUSY: begin
                if (m_ready) begin
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = r_cmd.rw ? m_data_out : 8'h00;
                    w_to_resp       = 1'b1;
                end else if (r_timer == c_DONE_LIM) begin
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = 8'h00;
                    w_to_resp       = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_err_nxt   = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Response identity always comes from the command currently on the bus
        if (w_to_resp) begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_addr_nxt  = r_cmd.addr;
            w_rsp_rw_nxt    = r_cmd.rw;
            w_state_nxt     = ST_RESP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cmd       <= '0;
            r_m_enable  <= 1'b0;
            r_timer     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_rw    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd       <= w_cmd_nxt;
            r_m_enable  <= w_m_enable_nxt;
            r_timer     <= w_timer_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_addr  <= w_rsp_addr_nxt;
            r_rsp_rw    <= w_rsp_rw_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    assign m_addr    = r_cmd.addr;
    assign m_data_in = r_cmd.wdata;
    assign m_rw      = r_cmd.rw;
    assign m_enable  = r_m_enable;
    assign rsp_valid = r_rsp_valid;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_rw    = r_rsp_rw;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_i2c_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_cmd_sequencer
//  Description : Self-checking bench with a behavioural I2C master model.
//  Revision    : 1.0
// ============================================================================
module tb_i2c_cmd_sequencer;

    localparam int FIFO_DEPTH = 4;
    localparam int ACCEPT_TO  = 64;
    localparam int DONE_TO    = 4096;
    localparam int M_NORMAL   = 0;
    localparam int M_STUCK_HI = 1;
    localparam int M_STUCK_LO = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_ready, rsp_rw, rsp_err;
    logic [6:0] rsp_addr;
    logic [7:0] rsp_rdata;
    logic [6:0] m_addr;
    logic [7:0] m_data_in, m_data_out;
    logic       m_rw, m_enable, m_ready, busy;

    typedef struct packed { logic [6:0] addr; logic rw; logic [7:0] rdata; logic err; } rsp_t;
    typedef struct packed { logic [6:0] addr; logic rw; logic [7:0] wdata; } iss_t;
    typedef struct { logic [6:0] addr; logic rw; logic [7:0] wdata; logic [7:0] exp_rdata; logic exp_err; } vec_t;

    rsp_t rsp_q[$];
    iss_t iss_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mst_mode = M_NORMAL;
    logic mst_release = 1'b0;

    i2c_cmd_sequencer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ACCEPT_TO  (ACCEPT_TO),
        .DONE_TO    (DONE_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_rw     (cmd_rw),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_addr   (rsp_addr),
        .rsp_rw     (rsp_rw),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .m_addr     (m_addr),
        .m_data_in  (m_data_in),
        .m_rw       (m_rw),
        .m_enable   (m_enable),
        .m_ready    (m_ready),
        .m_data_out (m_data_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_ctl"}, {cmd_ready, rsp_valid, m_enable, busy, rsp_err, rsp_rw}, 32'b100000);
        check({tag, "_mbus"}, {m_rw, m_addr, m_data_in}, 32'h0);
        check({tag, "_rsp"}, {rsp_addr, rsp_rdata}, 32'h0);
    endtask

    task automatic push(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                        input logic [7:0] erd, input logic eerr,
                        input bit exp_iss, input bit exp_rsp);
        int   n;
        iss_t ie;
        rsp_t re;
        n = 0;
        while (!cmd_ready && n < 10000) begin
            @(negedge clk);
            n++;
        end
        check("push_wait_ready", {31'b0, cmd_ready}, 32'h1);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_rw    = rw;
        cmd_wdata = wd;
        ie.addr = a; ie.rw = rw; ie.wdata = wd;
        re.addr = a; re.rw = rw; re.rdata = erd; re.err = eerr;
        if (exp_iss) iss_q.push_back(ie);
        if (exp_rsp) rsp_q.push_back(re);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || rsp_q.size() != 0 || iss_q.size() != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'b0, (n < 20000)}, 32'h1);
    endtask

    // Response collector: the handshake condition is sampled just before the edge
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst && rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got addr 0x%0h expected no response", rsp_addr);
                end else begin
                    e = rsp_q.pop_front();
                    check("rsp_addr", rsp_addr, e.addr);
                    check("rsp_rw", rsp_rw, e.rw);
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", rsp_err, e.err);
                end
            end
        end
    end

    // Behavioural master: accepts on the second enable cycle, completes 20 cycles later
    initial begin
        iss_t e;
        logic chk_lat;
        m_ready    = 1'b1;
        m_data_out = 8'h00;
        forever begin
            @(negedge clk);
            if (rst && m_enable) begin
                if (iss_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL iss_unexpected: got addr 0x%0h expected no issue", m_addr);
                end else begin
                    e = iss_q.pop_front();
                    check("iss_addr", m_addr, e.addr);
                    check("iss_rw", m_rw, e.rw);
                    check("iss_wdata", m_data_in, e.wdata);
                end
                if (mst_mode == M_STUCK_HI) begin
                    while (m_enable) @(negedge clk);
                end else begin
                    chk_lat = (mst_mode == M_NORMAL);
                    @(negedge clk);
                    m_ready = 1'b0;
                    if (chk_lat) repeat (20) @(negedge clk);
                    else while (!mst_release) @(negedge clk);
                    m_data_out = {1'b0, m_addr} ^ 8'hE7;
                    m_ready    = 1'b1;
                    if (chk_lat) begin
                        @(negedge clk);
                        check("rsp_latency", {31'b0, rsp_valid}, 32'h1);
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        vec_t fulls[5];
        int   n;

        vecs[0] = '{7'h2A, 1'b0, 8'hAA, 8'h00, 1'b0};
        vecs[1] = '{7'h2B, 1'b1, 8'h00, 8'hCC, 1'b0};
        vecs[2] = '{7'h10, 1'b1, 8'h3C, 8'hF7, 1'b0};
        vecs[3] = '{7'h7F, 1'b1, 8'hFF, 8'h98, 1'b0};
        vecs[4] = '{7'h00, 1'b0, 8'h55, 8'h00, 1'b0};
        vecs[5] = '{7'h55, 1'b1, 8'h01, 8'hB2, 1'b0};
        fulls[0] = '{7'h2A, 1'b0, 8'h30, 8'h00, 1'b0};
        fulls[1] = '{7'h2B, 1'b1, 8'h31, 8'hCC, 1'b0};
        fulls[2] = '{7'h2C, 1'b0, 8'h32, 8'h00, 1'b0};
        fulls[3] = '{7'h2D, 1'b1, 8'h33, 8'hCA, 1'b0};
        fulls[4] = '{7'h2F, 1'b0, 8'h34, 8'h00, 1'b0};

        rst = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_rw = 1'b0;
        cmd_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b1;
        @(negedge clk);

        // Single transactions with push-to-enable latency
        for (int i = 0; i < 6; i++) begin
            push(vecs[i].addr, vecs[i].rw, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, 1, 1);
            check("lat_edge_n", {31'b0, m_enable}, 32'h0);
            @(negedge clk);
            check("lat_edge_n1", {31'b0, m_enable}, 32'h1);
            wait_idle("vec_done");
        end

        // FIFO full with responses back-pressured; a blocked push must not enter
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push(fulls[i].addr, fulls[i].rw, fulls[i].wdata, fulls[i].exp_rdata, fulls[i].exp_err, 1, 1);
        check("full_ready", {31'b0, cmd_ready}, 32'h0);
        cmd_valid = 1'b1; cmd_addr = 7'h31; cmd_rw = 1'b0; cmd_wdata = 8'hEE;
        n = 0;
        repeat (30) begin
            if (cmd_ready) n++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("full_hold", n, 0);
        rsp_ready = 1'b1;
        wait_idle("full_drain");

        // Accept timeout: master never takes the command
        mst_mode = M_STUCK_HI;
        push(7'h41, 1'b1, 8'h00, 8'h00, 1'b1, 1, 1);
        n = 0;
        while (!m_enable && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (m_enable && n < ACCEPT_TO + 10) begin n++; @(negedge clk); end
        check("acc_to_len", n, ACCEPT_TO);
        wait_idle("acc_to_rsp");
        mst_mode = M_NORMAL;

        // Done timeout: master accepts but never finishes
        mst_release = 1'b0;
        mst_mode    = M_STUCK_LO;
        push(7'h42, 1'b1, 8'h00, 8'h00, 1'b1, 1, 1);
        n = 0;
        while (!m_enable && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (m_enable && n < ACCEPT_TO + 10) begin @(negedge clk); n++; end
        n = 0;
        while (!rsp_valid && n < DONE_TO + 10) begin n++; @(negedge clk); end
        check("done_to_len", n, DONE_TO);
        wait_idle("done_to_rsp");

        // Master still not ready: queued command must wait
        push(7'h43, 1'b0, 8'h99, 8'h00, 1'b0, 1, 1);
        n = 0;
        repeat (10) begin
            if (m_enable) n++;
            @(negedge clk);
        end
        check("idle_hold_enable", n, 0);
        check("idle_hold_busy", {31'b0, busy}, 32'h1);
        mst_mode    = M_NORMAL;
        mst_release = 1'b1;
        wait_idle("idle_release");

        // Reset while the master holds the bus; queued command is discarded
        mst_release = 1'b0;
        mst_mode    = M_STUCK_LO;
        push(7'h44, 1'b0, 8'h11, 8'h00, 1'b0, 1, 0);
        n = 0;
        while (!m_enable && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (m_enable && n < ACCEPT_TO + 10) begin @(negedge clk); n++; end
        push(7'h46, 1'b1, 8'h22, 8'h00, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset("rst_busy");
        rst = 1'b1;
        mst_mode    = M_NORMAL;
        mst_release = 1'b1;
        n = 0;
        repeat (30) begin
            if (rsp_valid || m_enable) n++;
            @(negedge clk);
        end
        check("rst_no_stale", n, 0);
        push(7'h45, 1'b0, 8'h5A, 8'h00, 1'b0, 1, 1);
        wait_idle("post_rst_write");

        check("queues_empty", rsp_q.size() + iss_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_cmd_sequencer.md
# i2c_cmd_sequencer

Upstream command sequencer for `i2c_controller`. It accepts I2C transactions from a host through a valid/ready command port and buffers them in a small FIFO. It issues each transaction to the master's `addr`/`data_in`/`rw`/`enable` inputs and tracks the master's `ready` handshake. On completion it returns one response per command: read data or error status.

## Interface

Parameters:
- `FIFO_DEPTH`, 4 — command FIFO entries (power of 2, ≥2)
- `ACCEPT_TO`, 64 — max cycles from `m_enable` rising until `m_ready` falls
- `DONE_TO`, 4096 — max cycles from master accept until `m_ready` rises

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `cmd_valid`  in  1  host command valid
- `cmd_ready`  out  1  FIFO not full
- `cmd_addr`  in  7  slave address
- `cmd_rw`  in  1  1 = read, 0 = write
- `cmd_wdata`  in  8  write byte (ignored for reads)
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  host accepts response
- `rsp_addr`  out  7  address of completed command
- `rsp_rw`  out  1  rw of completed command
- `rsp_rdata`  out  8  read byte; 0 for writes and errors
- `rsp_err`  out  1  timeout occurred
- `m_addr`  out  7  to master `addr`
- `m_data_in`  out  8  to master `data_in`
- `m_rw`  out  1  to master `rw`
- `m_enable`  out  1  to master `enable`
- `m_ready`  in  1  from master `ready` (1 = idle)
- `m_data_out`  in  8  from master `data_out`
- `busy`  out  1  FSM not in IDLE, or FIFO non-empty

## Operation

- Command push: occurs when `cmd_valid && cmd_ready`. `cmd_ready = !full`, derived from the registered count, so a push is never accepted while full, even when a pop happens in the same cycle.
- FSM states: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - Condition: FIFO non-empty and `m_ready==1`.
  - Action: pop the head into the command register; drive `m_addr`/`m_data_in`/`m_rw` from it; set `m_enable=1`; clear the timer; go to ISSUE.
- ISSUE:
  - Hold `m_enable=1`.
  - If `m_ready==0`: drop `m_enable`, clear the timer, go to BUSY.
  - Else if the timer reaches `ACCEPT_TO-1`: drop `m_enable`, set error, go to RESP.
- BUSY:
  - If `m_ready==1`: capture `m_data_out` into `rsp_rdata` when rw=1, else 0; go to RESP.
  - Else if the timer reaches `DONE_TO-1`: set error, `rsp_rdata=0`, go to RESP.
- RESP:
  - Assert `rsp_valid`; hold all `rsp_*` stable.
  - When `rsp_ready`: deassert `rsp_valid`, clear error, go to IDLE.
- Only one transaction is outstanding at a time. Pushes continue during ISSUE, BUSY and RESP.
- `m_addr`/`m_data_in`/`m_rw` stay stable from IDLE exit until the next pop.
- Timer: saturating counter, width `$clog2(DONE_TO)+1`.
- FIFO pointers: `$clog2(FIFO_DEPTH)` bits, wrap modulo depth; count has one extra bit.

## Timing

- Reset values (`rst==0` at a clock edge): FSM=IDLE, FIFO empty, `cmd_ready=1`, `rsp_valid=0`, `rsp_*=0`, `m_enable=0`, `m_addr=0`, `m_data_in=0`, `m_rw=0`, `busy=0`.
- Reset mid-transaction: `m_enable` drops the next edge. The in-flight command and FIFO contents are discarded and no response is issued.
- Latency, push to `m_enable`:
  - Push at edge N into an empty FIFO with FSM in IDLE.
  - `m_enable=1` after edge N+1.
- Latency, `m_ready` rise to `rsp_valid`: 1 cycle.
- Response to next issue:
  - The `rsp_ready` handshake occurs at edge R.
  - If a command is queued, the next `m_enable` goes high after edge R+1.
- `m_enable` is high for at least 1 and at most `ACCEPT_TO` cycles.
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged.
- `m_ready` low already in IDLE: the sequencer waits and does not pop.

## Structure

- Package `i2c_seq_pkg`:
  - FSM state enum: IDLE=0, ISSUE=1, BUSY=2, RESP=3.
  - Command record width constant: 16 bits = {rw, addr[6:0], wdata[7:0]}.
  - Default timeout constants.
- Sub-module `i2c_cmd_fifo`:
  - Synchronous FIFO, width 16, depth `FIFO_DEPTH`.
  - Ports: push, pop, din, dout, full, empty, active-low synchronous reset.
  - Instantiated once.

## Test plan

- Write: push addr 0x2A, rw=0, wdata 0xAA; behavioural master drops `ready` 2 cycles after `enable` and raises it 20 cycles later → `m_addr`=0x2A, `m_data_in`=0xAA during ISSUE; `rsp_valid` with `rsp_err=0`, `rsp_rdata`=0x00.
- Read: push 0x2B, rw=1; master returns `data_out`=0xCC → `rsp_rdata`=0xCC, `rsp_rw=1`, `rsp_addr`=0x2B.
- FIFO full: hold `rsp_ready=0` and push 0x2A–0x2D plus 0x2F → `cmd_ready` drops after the FIFO fills. Responses return in push order, and no command is lost or duplicated.
- Accept timeout: `m_ready` stuck at 1 → `m_enable` high exactly `ACCEPT_TO` cycles, then `rsp_err=1`, `rsp_rdata`=0.
- Done timeout: master accepts but never raises `ready` → `rsp_err=1` after `DONE_TO` cycles in BUSY.
- Reset in BUSY: assert `rst=0` for 1 cycle → all outputs at reset values, FIFO empty, no stale `rsp_valid`; a subsequent write completes normally.
